// File: rtl/uart_pkg.sv
// Shared encodings for the UART parity engine.
// Holds the parity modes, FSM states and the mode-check helper.
package uart_pkg;

    typedef enum logic [2:0] {
        PM_NONE  = 3'd0,
        PM_EVEN  = 3'd1,
        PM_ODD   = 3'd2,
        PM_MARK  = 3'd3,
        PM_SPACE = 3'd4
    } par_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    // Modes 5-7 are reserved and behave like none.
    function automatic logic mode_checked(input logic [2:0] mode);
        return (mode >= PM_EVEN) && (mode <= PM_SPACE);
    endfunction

endpackage

// File: rtl/uart_par_reduce.sv
// Combinational parity reduction plus parity-mode mapping.
// Shared by the parallel and serial paths of the engine.
module uart_par_reduce
    import uart_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] data,
    input  logic [2:0]        mode,
    output logic              par
);

    logic x;

    always_comb begin
        x   = ^data;
        par = 1'b0;
        unique case (1'b1)
            mode == PM_EVEN:  par = x;
            mode == PM_ODD:   par = ~x;
            mode == PM_MARK:  par = 1'b1;
            mode == PM_SPACE: par = 1'b0;
            default:          par = 1'b0;
        endcase
    end

endmodule

// File: rtl/uart_parity_engine.sv
// UART parity generator/checker with parallel and bit-serial paths.
// Result is registered; HOLD keeps it for the received-parity compare.
module uart_parity_engine
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CHK_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] P_DATA,
    input  logic              Data_Valid,
    input  logic              Ser_En,
    input  logic [2:0]        PAR_MODE,
    input  logic              Bit_Strobe,
    input  logic              Ser_Bit,
    input  logic              Par_Strobe,
    input  logic              Rx_Par,
    input  logic              Err_Clr,
    output logic              Busy,
    output logic              Par_bit,
    output logic              Par_Valid,
    output logic              Par_Err
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    state_e            state_q;
    state_e            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              acc_q;
    logic [2:0]        mode_q;

    logic              accept;
    logic              last_bit;
    logic              load_par;
    logic              set_err;
    logic              acc_nxt;
    logic              red_par;
    logic [DATA_W-1:0] red_data;
    logic [2:0]        red_mode;

    assign acc_nxt  = acc_q ^ Ser_Bit;
    assign load_par = (accept && !Ser_En) || last_bit;
    assign Busy     = (state_q == ST_ACCUM);

    // In ACCUM the running XOR stands in for the data word.
    assign red_data = Busy ? {{(DATA_W-1){1'b0}}, acc_nxt} : P_DATA;
    assign red_mode = Busy ? mode_q : PAR_MODE;

    uart_par_reduce #(
        .DATA_W (DATA_W)
    ) u_reduce (
        .data   (red_data),
        .mode   (red_mode),
        .par    (red_par)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        last_bit = 1'b0;
        set_err  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                accept = Data_Valid;
            end
            ST_ACCUM: begin
                last_bit = Bit_Strobe && (cnt_q == CNT_W'(DATA_W - 1));
                if (last_bit) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                accept  = Data_Valid;
                set_err = (CHK_EN != 0) && Par_Strobe &&
                          mode_checked(mode_q) && (Rx_Par != Par_bit);
                if (Par_Strobe) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // A new request in HOLD overrides the return to IDLE.
        if (accept) state_d = Ser_En ? ST_ACCUM : ST_HOLD;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            acc_q     <= 1'b0;
            mode_q    <= PM_NONE;
            Par_bit   <= 1'b0;
            Par_Valid <= 1'b0;
            Par_Err   <= 1'b0;
        end else begin
            Par_Valid <= load_par;
            if (load_par) Par_bit <= red_par;
            if (accept) mode_q <= PAR_MODE;
            if (accept && Ser_En) begin
                cnt_q <= '0;
                acc_q <= 1'b0;
            end else if (Busy && Bit_Strobe) begin
                cnt_q <= cnt_q + CNT_W'(1);
                acc_q <= acc_nxt;
            end
            if (set_err)      Par_Err <= 1'b1;
            else if (Err_Clr) Par_Err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_parity_engine.sv
// Self-checking bench for uart_parity_engine (DATA_W=8 and DATA_W=7).
// Vector table, directed corner sequences and a randomized model run.
module tb_uart_parity_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] P_DATA;
    logic       Data_Valid, Ser_En, Bit_Strobe, Ser_Bit;
    logic       Par_Strobe, Rx_Par, Err_Clr;
    logic [2:0] PAR_MODE;

    logic busy8, pb8, pv8, err8;
    logic busy7, pb7, pv7, err7;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_parity_engine #(.DATA_W(8), .CHK_EN(1)) dut8 (
        .clk(clk), .rst(rst), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
        .Ser_En(Ser_En), .PAR_MODE(PAR_MODE), .Bit_Strobe(Bit_Strobe),
        .Ser_Bit(Ser_Bit), .Par_Strobe(Par_Strobe), .Rx_Par(Rx_Par),
        .Err_Clr(Err_Clr), .Busy(busy8), .Par_bit(pb8),
        .Par_Valid(pv8), .Par_Err(err8)
    );

    uart_parity_engine #(.DATA_W(7), .CHK_EN(1)) dut7 (
        .clk(clk), .rst(rst), .P_DATA(P_DATA[6:0]), .Data_Valid(Data_Valid),
        .Ser_En(Ser_En), .PAR_MODE(PAR_MODE), .Bit_Strobe(Bit_Strobe),
        .Ser_Bit(Ser_Bit), .Par_Strobe(Par_Strobe), .Rx_Par(Rx_Par),
        .Err_Clr(Err_Clr), .Busy(busy7), .Par_bit(pb7),
        .Par_Valid(pv7), .Par_Err(err7)
    );

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] mode;
        logic       exp;
    } vec_t;

    vec_t vecs [12];

    function automatic logic exp_par(input logic [2:0] m, input int ones);
        case (m)
            3'd1:    return (ones % 2) == 1;
            3'd2:    return (ones % 2) == 0;
            3'd3:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_checked(input logic [2:0] m);
        return (m >= 3'd1) && (m <= 3'd4);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        Data_Valid = 1'b0;
        Ser_En     = 1'b0;
        Bit_Strobe = 1'b0;
        Ser_Bit    = 1'b0;
        Par_Strobe = 1'b0;
        Rx_Par     = 1'b0;
        Err_Clr    = 1'b0;
    endtask

    task automatic do_reset();
        idle_in();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic par_op(input logic [7:0] d, input logic [2:0] m);
        P_DATA     = d;
        PAR_MODE   = m;
        Ser_En     = 1'b0;
        Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0;
    endtask

    task automatic ser_start(input logic [2:0] m);
        PAR_MODE   = m;
        Ser_En     = 1'b1;
        Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0;
        Ser_En     = 1'b0;
    endtask

    task automatic strobe(input logic b);
        Bit_Strobe = 1'b1;
        Ser_Bit    = b;
        tick();
        Bit_Strobe = 1'b0;
        Ser_Bit    = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0] bits7;
        logic [7:0] bits;
        logic [7:0] d;
        logic [2:0] m;
        logic       expp, err_m, mism, clr;
        int         r;

        vecs[0]  = '{8'hB4, 3'd1, 1'b0};
        vecs[1]  = '{8'hB4, 3'd2, 1'b1};
        vecs[2]  = '{8'h00, 3'd3, 1'b1};
        vecs[3]  = '{8'h00, 3'd4, 1'b0};
        vecs[4]  = '{8'h00, 3'd0, 1'b0};
        vecs[5]  = '{8'h00, 3'd6, 1'b0};
        vecs[6]  = '{8'hFF, 3'd1, 1'b0};
        vecs[7]  = '{8'h01, 3'd1, 1'b1};
        vecs[8]  = '{8'h01, 3'd2, 1'b0};
        vecs[9]  = '{8'h7F, 3'd3, 1'b1};
        vecs[10] = '{8'h7F, 3'd7, 1'b0};
        vecs[11] = '{8'h80, 3'd4, 1'b0};

        idle_in();
        P_DATA   = 8'h00;
        PAR_MODE = 3'd0;
        rst      = 1'b1;
        #1;
        chk("rst_busy", busy8, 0);
        chk("rst_par_bit", pb8, 0);
        chk("rst_par_valid", pv8, 0);
        chk("rst_par_err", err8, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("idle_par_valid", pv8, 0);

        for (int i = 0; i < 12; i++) begin
            par_op(vecs[i].data, vecs[i].mode);
            chk($sformatf("vec%0d_valid", i), pv8, 1);
            chk($sformatf("vec%0d_par", i), pb8, vecs[i].exp);
            PAR_MODE = ~vecs[i].mode;
            tick();
            chk($sformatf("vec%0d_pulse", i), pv8, 0);
            chk($sformatf("vec%0d_hold", i), pb8, vecs[i].exp);
        end

        // none mode skips the compare
        par_op(8'h00, 3'd0);
        Par_Strobe = 1'b1;
        Rx_Par     = 1'b1;
        tick();
        idle_in();
        chk("none_no_err", err8, 0);

        // DATA_W=7 serial odd frame
        do_reset();
        bits7 = 7'b0001011;
        ser_start(3'd2);
        chk("w7_busy_start", busy7, 1);
        for (int i = 0; i < 7; i++) begin
            strobe(bits7[i]);
            if (i < 6) begin
                chk($sformatf("w7_busy%0d", i), busy7, 1);
                chk($sformatf("w7_novalid%0d", i), pv7, 0);
            end
        end
        chk("w7_valid", pv7, 1);
        chk("w7_par", pb7, 0);
        chk("w7_busy_end", busy7, 0);
        Par_Strobe = 1'b1;
        Rx_Par     = 1'b1;
        tick();
        idle_in();
        chk("w7_pulse", pv7, 0);
        chk("w7_err", err7, 1);

        // reset mid-frame abandons it
        do_reset();
        ser_start(3'd1);
        strobe(1'b1);
        strobe(1'b0);
        strobe(1'b1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy8, 0);
        chk("midrst_valid", pv8, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("midrst_valid2", pv8, 0);
        chk("midrst_par", pb8, 0);
        bits = 8'b0000_0111;
        ser_start(3'd1);
        for (int i = 0; i < 8; i++) strobe(bits[i]);
        chk("rerun_valid", pv8, 1);
        chk("rerun_par", pb8, 1);

        // matching compare, then stray strobes in IDLE
        Par_Strobe = 1'b1;
        Rx_Par     = 1'b1;
        tick();
        idle_in();
        chk("match_no_err", err8, 0);
        for (int i = 0; i < 3; i++) begin
            Bit_Strobe = 1'b1;
            Ser_Bit    = 1'b1;
            tick();
            chk($sformatf("idle_strobe_valid%0d", i), pv8, 0);
            chk($sformatf("idle_strobe_par%0d", i), pb8, 1);
            chk($sformatf("idle_strobe_busy%0d", i), busy8, 0);
        end
        idle_in();

        // Data_Valid and mode change during ACCUM are ignored
        ser_start(3'd2);
        for (int i = 0; i < 7; i++) begin
            Data_Valid = 1'b1;
            Ser_En     = 1'b0;
            P_DATA     = 8'hFF;
            PAR_MODE   = 3'd3;
            strobe(1'b0);
            chk($sformatf("accum_dv_valid%0d", i), pv8, 0);
            chk($sformatf("accum_dv_busy%0d", i), busy8, 1);
        end
        Data_Valid = 1'b0;
        strobe(1'b1);
        chk("accum_dv_done", pv8, 1);
        chk("accum_dv_par", pb8, 0);
        Par_Strobe = 1'b1;
        Rx_Par     = 1'b0;
        tick();
        idle_in();
        chk("accum_dv_err", err8, 0);

        // set wins over clear
        par_op(8'hB4, 3'd1);
        chk("clr_par", pb8, 0);
        Par_Strobe = 1'b1;
        Rx_Par     = 1'b1;
        Err_Clr    = 1'b1;
        tick();
        idle_in();
        chk("set_wins", err8, 1);
        Err_Clr = 1'b1;
        tick();
        idle_in();
        chk("clr_alone", err8, 0);

        // randomized transactions against the reference model
        do_reset();
        err_m = 1'b0;
        for (int t = 0; t < 150; t++) begin
            m = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                d    = 8'($urandom);
                expp = exp_par(m, $countones(d));
                par_op(d, m);
            end else begin
                bits = 8'($urandom);
                expp = exp_par(m, $countones(bits));
                ser_start(m);
                for (int i = 0; i < 8; i++) begin
                    for (int g = $urandom_range(0, 2); g > 0; g--) begin
                        Ser_Bit    = 1'($urandom);
                        PAR_MODE   = 3'($urandom);
                        Data_Valid = 1'($urandom);
                        Ser_En     = 1'($urandom);
                        P_DATA     = 8'($urandom);
                        tick();
                        chk($sformatf("rnd%0d_gap_valid", t), pv8, 0);
                        chk($sformatf("rnd%0d_gap_busy", t), busy8, 1);
                    end
                    idle_in();
                    strobe(bits[i]);
                end
            end
            chk($sformatf("rnd%0d_valid", t), pv8, 1);
            chk($sformatf("rnd%0d_par", t), pb8, expp);
            chk($sformatf("rnd%0d_busy", t), busy8, 0);
            idle_in();
            PAR_MODE = 3'($urandom);
            r        = $urandom_range(0, 3);
            clr      = 1'($urandom);
            Err_Clr  = clr;
            if (r < 2) begin
                Par_Strobe = 1'b1;
                Rx_Par     = 1'($urandom);
                mism       = is_checked(m) && (Rx_Par != expp);
                err_m      = mism ? 1'b1 : (clr ? 1'b0 : err_m);
            end else begin
                err_m = clr ? 1'b0 : err_m;
            end
            tick();
            idle_in();
            chk($sformatf("rnd%0d_pulse", t), pv8, 0);
            chk($sformatf("rnd%0d_hold", t), pb8, expp);
            chk($sformatf("rnd%0d_err", t), err8, err_m);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
